// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and source encoding for the CDB arbiter slice.
package cdb_arbiter_pkg;

  localparam int unsigned CDB_FIFO_DEPTH = 4;
  localparam int unsigned CDB_ROB_W      = 4;
  localparam int unsigned CDB_VALUE_W    = 32;

  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_MEM = 1'b1
  } cdb_src_e;

  // Round-robin tie break: favour whichever source did not win last time.
  function automatic cdb_src_e tie_winner(input cdb_src_e last_grant);
    return (last_grant == CDB_SRC_MEM) ? CDB_SRC_ALU : CDB_SRC_MEM;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-result / CDB broadcast bundle between the issue pipeline and the arbiter.
interface cdb_arbiter_if #(
  parameter int unsigned ROB_W = 4
);
  logic             rdy_in;
  logic             flush_input;
  logic [ROB_W-1:0] alu_rob_id;
  logic [31:0]      alu_value;
  logic [ROB_W-1:0] mem_rob_id;
  logic [31:0]      mem_value;
  logic             alu_stall;
  logic             mem_stall;
  logic [ROB_W-1:0] cdb_rob_id;
  logic [31:0]      cdb_value;
  logic             overflow_err;

  modport master (
    output rdy_in, flush_input, alu_rob_id, alu_value, mem_rob_id, mem_value,
    input  alu_stall, mem_stall, cdb_rob_id, cdb_value, overflow_err
  );

  modport slave (
    input  rdy_in, flush_input, alu_rob_id, alu_value, mem_rob_id, mem_value,
    output alu_stall, mem_stall, cdb_rob_id, cdb_value, overflow_err
  );
endinterface

// File: rtl/cdb_arbiter_fifo.sv
// Small per-producer result FIFO; push into a full FIFO is accepted only if it is popped on the same edge.
module cdb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 36
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter draining the ALU and MEM result FIFOs onto a single registered CDB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = CDB_FIFO_DEPTH,
  parameter int unsigned ROB_W = CDB_ROB_W
) (
  input  logic          clk_in,
  input  logic          rst_in,
  cdb_arbiter_if.slave  bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned W  = ROB_W + CDB_VALUE_W;

  logic          go;
  logic          clr;
  logic          alu_push;
  logic          mem_push;
  logic          alu_pop;
  logic          mem_pop;
  logic [W-1:0]  alu_head;
  logic [W-1:0]  mem_head;
  logic          alu_empty;
  logic          mem_empty;
  logic          alu_full;
  logic          mem_full;
  logic [CW-1:0] alu_count;
  logic [CW-1:0] mem_count;
  logic          grant_alu;
  logic          grant_mem;
  logic [W-1:0]  grant_data;
  logic          overflow_set;
  cdb_src_e      last_grant;

  assign go  = bus.rdy_in && !bus.flush_input;
  assign clr = bus.rdy_in && bus.flush_input;

  assign alu_push = go && (bus.alu_rob_id != '0);
  assign mem_push = go && (bus.mem_rob_id != '0);

  // Grant the lone non-empty head, or the one not served last on a tie.
  assign grant_alu = !alu_empty && (mem_empty || (tie_winner(last_grant) == CDB_SRC_ALU));
  assign grant_mem = !mem_empty && !grant_alu;
  assign alu_pop   = go && grant_alu;
  assign mem_pop   = go && grant_mem;

  assign grant_data = grant_alu ? alu_head : (grant_mem ? mem_head : '0);

  assign overflow_set = (alu_push && alu_full && !alu_pop) ||
                        (mem_push && mem_full && !mem_pop);

  // Spare entry absorbs the result already in flight in the producer.
  assign bus.alu_stall = (alu_count >= CW'(DEPTH - 1));
  assign bus.mem_stall = (mem_count >= CW'(DEPTH - 1));

  cdb_fifo #(.DEPTH(DEPTH), .W(W)) u_alu_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (clr),
    .push   (alu_push),
    .pop    (alu_pop),
    .din    ({bus.alu_rob_id, bus.alu_value}),
    .dout   (alu_head),
    .empty  (alu_empty),
    .full   (alu_full),
    .count  (alu_count)
  );

  cdb_fifo #(.DEPTH(DEPTH), .W(W)) u_mem_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (clr),
    .push   (mem_push),
    .pop    (mem_pop),
    .din    ({bus.mem_rob_id, bus.mem_value}),
    .dout   (mem_head),
    .empty  (mem_empty),
    .full   (mem_full),
    .count  (mem_count)
  );

  // CDB output registers, arbitration history and sticky overflow flag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bus.cdb_rob_id   <= '0;
      bus.cdb_value    <= '0;
      bus.overflow_err <= 1'b0;
      last_grant       <= CDB_SRC_MEM;
    end else if (bus.rdy_in) begin
      if (bus.flush_input) begin
        bus.cdb_rob_id <= '0;
        bus.cdb_value  <= '0;
        last_grant     <= CDB_SRC_MEM;
      end else begin
        bus.cdb_rob_id <= grant_data[W-1 -: ROB_W];
        bus.cdb_value  <= grant_data[CDB_VALUE_W-1:0];
        if (grant_alu)         last_grant <= CDB_SRC_ALU;
        else if (grant_mem)    last_grant <= CDB_SRC_MEM;
        if (overflow_set)      bus.overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter.
module tb_cdb_arbiter;

  logic clk_in;
  logic rst_in;
  int   n_cmp;
  int   n_err;

  cdb_arbiter_if #(.ROB_W(4)) bus_if ();

  cdb_arbiter #(.DEPTH(4), .ROB_W(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus_if.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus_if.alu_rob_id  = '0;
    bus_if.alu_value   = '0;
    bus_if.mem_rob_id  = '0;
    bus_if.mem_value   = '0;
    bus_if.flush_input = 1'b0;
    bus_if.rdy_in      = 1'b1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    idle();
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    idle();
    #2;
    n_cmp++;
    if (bus_if.cdb_rob_id !== 4'd0 || bus_if.cdb_value !== 32'd0) begin
      n_err++;
      $display("FAIL reset_cdb: got id %0d val %h, want 0/0", bus_if.cdb_rob_id, bus_if.cdb_value);
    end
    n_cmp++;
    if (bus_if.alu_stall !== 1'b0 || bus_if.mem_stall !== 1'b0 || bus_if.overflow_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: got stalls %b%b ovf %b, want 000",
               bus_if.alu_stall, bus_if.mem_stall, bus_if.overflow_err);
    end
    do_reset();
  endtask

  task automatic test_idle_path();
    logic [3:0]  exp_id [4];
    logic [31:0] exp_v  [4];
    exp_id = '{4'd0, 4'd0, 4'd3, 4'd0};
    exp_v  = '{32'd0, 32'd0, 32'h11, 32'd0};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c == 0) begin
        bus_if.alu_rob_id = 4'd3;
        bus_if.alu_value  = 32'h11;
      end
      n_cmp++;
      if (bus_if.cdb_rob_id !== exp_id[c] || bus_if.cdb_value !== exp_v[c]) begin
        n_err++;
        $display("FAIL idle_path_c%0d: got %0d/%h, want %0d/%h", c + 1,
                 bus_if.cdb_rob_id, bus_if.cdb_value, exp_id[c], exp_v[c]);
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0]  exp_id [5];
    logic [31:0] exp_v  [5];
    exp_id = '{4'd0, 4'd0, 4'd2, 4'd5, 4'd0};
    exp_v  = '{32'd0, 32'd0, 32'hA, 32'hB, 32'd0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c == 0) begin
        bus_if.alu_rob_id = 4'd2;  bus_if.alu_value = 32'hA;
        bus_if.mem_rob_id = 4'd5;  bus_if.mem_value = 32'hB;
      end
      n_cmp++;
      if (bus_if.cdb_rob_id !== exp_id[c] || bus_if.cdb_value !== exp_v[c]) begin
        n_err++;
        $display("FAIL simultaneous_c%0d: got %0d/%h, want %0d/%h", c + 1,
                 bus_if.cdb_rob_id, bus_if.cdb_value, exp_id[c], exp_v[c]);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_id [11];
    logic       exp_ms [11];
    logic [31:0] ev;
    exp_id = '{4'd0, 4'd0, 4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11, 4'd4, 4'd12, 4'd0};
    exp_ms = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int c = 0; c < 11; c++) begin
      idle();
      if (c < 4) begin
        bus_if.alu_rob_id = 4'(c + 1);
        bus_if.alu_value  = 32'(c + 1) * 32'h101;
        bus_if.mem_rob_id = 4'(c + 9);
        bus_if.mem_value  = 32'(c + 9) * 32'h101;
      end
      ev = 32'(exp_id[c]) * 32'h101;
      n_cmp++;
      if (bus_if.cdb_rob_id !== exp_id[c] || bus_if.cdb_value !== ev) begin
        n_err++;
        $display("FAIL round_robin_c%0d: got %0d/%h, want %0d/%h", c + 1,
                 bus_if.cdb_rob_id, bus_if.cdb_value, exp_id[c], ev);
      end
      n_cmp++;
      if (bus_if.mem_stall !== exp_ms[c] || bus_if.alu_stall !== 1'b0) begin
        n_err++;
        $display("FAIL rr_stall_c%0d: got alu %b mem %b, want alu 0 mem %b", c + 1,
                 bus_if.alu_stall, bus_if.mem_stall, exp_ms[c]);
      end
      tick();
    end
  endtask

  task automatic test_overflow();
    int alu_seen;
    int mem_seen;
    alu_seen = 0;
    mem_seen = 0;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      idle();
      if (c <= 9) begin
        bus_if.alu_rob_id = 4'(c);
        bus_if.alu_value  = 32'(c);
      end
      if (c <= 6) begin
        bus_if.mem_rob_id = 4'(c + 9);
        bus_if.mem_value  = 32'(c + 9);
      end
      if (bus_if.cdb_rob_id != 4'd0 && bus_if.cdb_rob_id < 4'd10) alu_seen++;
      if (bus_if.cdb_rob_id >= 4'd10) mem_seen++;
      if (c == 5 || c == 6) begin
        n_cmp++;
        if (bus_if.alu_stall !== (c == 6)) begin
          n_err++;
          $display("FAIL ovf_alu_stall_c%0d: got %b, want %b", c, bus_if.alu_stall, c == 6);
        end
      end
      if (c == 9 || c == 10 || c == 20) begin
        n_cmp++;
        if (bus_if.overflow_err !== (c != 9)) begin
          n_err++;
          $display("FAIL ovf_flag_c%0d: got %b, want %b", c, bus_if.overflow_err, c != 9);
        end
      end
      tick();
    end
    n_cmp++;
    if (alu_seen != 8 || mem_seen != 6) begin
      n_err++;
      $display("FAIL ovf_drain: got alu %0d mem %0d broadcasts, want 8 and 6", alu_seen, mem_seen);
    end
    bus_if.flush_input = 1'b1;
    tick();
    idle();
    tick();
    n_cmp++;
    if (bus_if.overflow_err !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky_flush: got %b, want 1", bus_if.overflow_err);
    end
  endtask

  task automatic test_async_reset();
    idle();
    bus_if.alu_rob_id = 4'd5;  bus_if.alu_value = 32'h55;
    tick();
    bus_if.alu_rob_id = 4'd6;  bus_if.alu_value = 32'h66;
    tick();
    idle();
    n_cmp++;
    if (bus_if.cdb_rob_id !== 4'd5 || bus_if.overflow_err !== 1'b1) begin
      n_err++;
      $display("FAIL areset_pre: got id %0d ovf %b, want 5 and 1", bus_if.cdb_rob_id, bus_if.overflow_err);
    end
    #2 rst_in = 1'b1;
    #1;
    n_cmp++;
    if (bus_if.cdb_rob_id !== 4'd0 || bus_if.cdb_value !== 32'd0 || bus_if.overflow_err !== 1'b0) begin
      n_err++;
      $display("FAIL areset_now: got id %0d val %h ovf %b, want 0/0/0",
               bus_if.cdb_rob_id, bus_if.cdb_value, bus_if.overflow_err);
    end
    #1 rst_in = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus_if.cdb_rob_id !== 4'd0) begin
      n_err++;
      $display("FAIL areset_discard: got id %0d, want 0", bus_if.cdb_rob_id);
    end
  endtask

  task automatic test_flush();
    logic [3:0] exp_id [6];
    do_reset();
    bus_if.alu_rob_id = 4'd1;  bus_if.mem_rob_id = 4'd9;
    tick();
    bus_if.alu_rob_id = 4'd2;  bus_if.mem_rob_id = 4'd10;
    tick();
    bus_if.alu_rob_id = 4'd7;  bus_if.mem_rob_id = 4'd8;
    bus_if.flush_input = 1'b1;
    tick();
    idle();
    n_cmp++;
    if (bus_if.cdb_rob_id !== 4'd0 || bus_if.alu_stall !== 1'b0 || bus_if.mem_stall !== 1'b0) begin
      n_err++;
      $display("FAIL flush_clear: got id %0d stalls %b%b, want 0 and 00",
               bus_if.cdb_rob_id, bus_if.alu_stall, bus_if.mem_stall);
    end
    exp_id = '{4'd0, 4'd0, 4'd6, 4'd4, 4'd0, 4'd0};
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c == 0) begin
        bus_if.alu_rob_id = 4'd6;  bus_if.alu_value = 32'h66;
        bus_if.mem_rob_id = 4'd4;  bus_if.mem_value = 32'h44;
      end
      n_cmp++;
      if (bus_if.cdb_rob_id !== exp_id[c]) begin
        n_err++;
        $display("FAIL flush_after_c%0d: got %0d, want %0d", c, bus_if.cdb_rob_id, exp_id[c]);
      end
      tick();
    end
  endtask

  task automatic test_rdy_hold();
    logic [3:0] exp_id [8];
    exp_id = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd0};
    do_reset();
    bus_if.alu_rob_id = 4'd1;  bus_if.alu_value = 32'h10;
    bus_if.mem_rob_id = 4'd2;  bus_if.mem_value = 32'h20;
    tick();
    // cycle 2 onward
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c == 0) begin
        bus_if.alu_rob_id = 4'd3;  bus_if.alu_value = 32'h30;
      end
      if (c >= 1 && c <= 3) begin
        bus_if.rdy_in     = 1'b0;
        bus_if.alu_rob_id = 4'd9;  bus_if.alu_value = 32'h90;
      end
      n_cmp++;
      if (bus_if.cdb_rob_id !== exp_id[c]) begin
        n_err++;
        $display("FAIL rdy_hold_c%0d: got %0d, want %0d", c + 2, bus_if.cdb_rob_id, exp_id[c]);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_idle_path();
    test_simultaneous();
    test_round_robin();
    test_overflow();
    test_async_reset();
    test_flush();
    test_rdy_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
